// File: rtl/rggen_external_apb_bridge.sv
// Bridges one registered external-window request into a single APB4 master transfer and
// returns a one-cycle ready pulse. Optional ACCESS timeout: RGGEN_EXTERNAL_APB_TIMEOUT_EN.
module rggen_external_apb_bridge #(
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned STROBE_WIDTH   = BUS_WIDTH / 8,
  parameter logic [2:0]  PPROT_VALUE    = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_external_valid,
  input  logic [1:0]               i_external_access,
  input  logic [ADDRESS_WIDTH-1:0] i_external_address,
  input  logic [BUS_WIDTH-1:0]     i_external_data,
  input  logic [STROBE_WIDTH-1:0]  i_external_strobe,
  output logic                     o_external_ready,
  output logic [1:0]               o_external_status,
  output logic [BUS_WIDTH-1:0]     o_external_data,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic                     o_pwrite,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  output logic [STROBE_WIDTH-1:0]  o_pstrb,
  input  logic                     i_pready,
  input  logic [BUS_WIDTH-1:0]     i_prdata,
  input  logic                     i_pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResponse} state_e;

  state_e                   state_q, state_d;
  logic                     psel_q, psel_d;
  logic                     penable_q, penable_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic                     pwrite_q, pwrite_d;
  logic [BUS_WIDTH-1:0]     pwdata_q, pwdata_d;
  logic [STROBE_WIDTH-1:0]  pstrb_q, pstrb_d;
  logic                     ready_q, ready_d;
  logic [1:0]               status_q, status_d;
  logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;
  logic                     timeout;

  // Only bit 0 of the access code matters to APB.
  logic unused_access;
  assign unused_access = i_external_access[1];

`ifdef RGGEN_EXTERNAL_APB_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;

  // Terminate on the cycle the count would reach the limit; PREADY wins a tie.
  assign timeout = !i_pready && (({1'b0, wait_cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StSetup) begin
      wait_cnt_d = '0;
    end else if (state_q == StAccess && !i_pready) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    ready_d   = 1'b0;
    status_d  = status_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (i_external_valid) begin
          paddr_d  = i_external_address;
          pwrite_d = i_external_access[0];
          pwdata_d = i_external_access[0] ? i_external_data : '0;
          pstrb_d  = i_external_access[0] ? i_external_strobe : '0;
          psel_d   = 1'b1;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        if (i_pready || timeout) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          state_d   = StResponse;
          if (i_pready) begin
            status_d = i_pslverr ? 2'b10 : 2'b00;
            rdata_d  = pwrite_q ? '0 : i_prdata;
          end else begin
            status_d = 2'b10;
            rdata_d  = '0;
          end
        end
      end
      StResponse: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      ready_q   <= 1'b0;
      status_q  <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      ready_q   <= ready_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_external_ready  = ready_q;
  assign o_external_status = status_q;
  assign o_external_data   = rdata_q;
  assign o_psel            = psel_q;
  assign o_penable         = penable_q;
  assign o_paddr           = paddr_q;
  assign o_pprot           = PPROT_VALUE;
  assign o_pwrite          = pwrite_q;
  assign o_pwdata          = pwdata_q;
  assign o_pstrb           = pstrb_q;

endmodule

// File: doc/rggen_external_apb_bridge.md
Name: rggen_external_apb_bridge

Overview:
Downstream stage of the external-register block. Consumes its registered valid/ready external request (access, address, write data, byte strobe) and runs one APB4 master transfer per request. Returns a one-cycle ready pulse with status and read data. Sits between the register map's external window and an APB4 slave.

Parameters:
ADDRESS_WIDTH, 8, width of external address and PADDR
BUS_WIDTH, 32, data width; multiple of 8
STROBE_WIDTH, BUS_WIDTH/8, byte strobe width
PPROT_VALUE, 3'b000, constant driven on PPROT
TIMEOUT_CYCLES, 255, ACCESS-phase wait limit; used only with the optional feature; range 1..65535

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_external_valid  in  1  request valid; held until ready pulse
i_external_access  in  2  bit0=1 write, bit0=0 read
i_external_address  in  ADDRESS_WIDTH  window-relative address
i_external_data  in  BUS_WIDTH  write data
i_external_strobe  in  STROBE_WIDTH  byte enables
o_external_ready  out  1  one-cycle completion pulse
o_external_status  out  2  00 OKAY, 10 SLVERR; valid with ready
o_external_data  out  BUS_WIDTH  read data; valid with ready
o_psel  out  1  APB PSEL
o_penable  out  1  APB PENABLE
o_paddr  out  ADDRESS_WIDTH  APB PADDR
o_pprot  out  3  APB PPROT (= PPROT_VALUE)
o_pwrite  out  1  APB PWRITE
o_pwdata  out  BUS_WIDTH  APB PWDATA
o_pstrb  out  STROBE_WIDTH  APB PSTRB
i_pready  in  1  APB PREADY
i_prdata  in  BUS_WIDTH  APB PRDATA
i_pslverr  in  1  APB PSLVERR

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- Reset values: all outputs 0 except o_pprot (= PPROT_VALUE); state IDLE.
- All outputs driven from flops; no combinational input-to-output path.
- FSM: IDLE, SETUP, ACCESS, RESPONSE.
- IDLE: if i_external_valid=1, capture request into APB regs and go to SETUP:
  - o_paddr=address, o_pwrite=access[0]
  - o_pwdata=data for writes, 0 for reads
  - o_pstrb=strobe for writes, 0 for reads
- SETUP: o_psel=1, o_penable=0; next cycle go to ACCESS.
- ACCESS: o_psel=1, o_penable=1.
  - On i_pready=1: capture status (i_pslverr ? 10 : 00) and data (read ? i_prdata : 0); drop psel/penable; go to RESPONSE.
  - Otherwise hold state and all APB outputs stable.
- RESPONSE: o_external_ready=1 for exactly one cycle with the captured status/data; then IDLE.
- o_external_status/o_external_data hold their last captured values outside RESPONSE.
- Latency: valid sampled at cycle N; PSEL rises N+1; PENABLE rises N+2; with zero-wait PREADY, ready pulses at N+3. Each PREADY wait cycle adds one cycle.
- Back-to-back: IDLE ignores valid in the cycle after RESPONSE only because upstream has already dropped valid. No further qualification.
- Request inputs are sampled only in IDLE; changes mid-transfer are ignored.
- Reset mid-transfer: APB outputs drop immediately (asynchronous) and the transfer is abandoned; no ready is issued.
- i_pready/i_pslverr/i_prdata are ignored outside ACCESS.

Optional Feature:
RGGEN_EXTERNAL_APB_TIMEOUT_EN
- Defined: a 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with i_pready=0.
  - When the count reaches TIMEOUT_CYCLES with i_pready=0, terminate: drop psel/penable, go to RESPONSE with status 10 and data 0.
  - If i_pready=1 arrives in the same cycle as the limit, PREADY wins and the normal response is returned.
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Write: addr 0x14, data 0xA5A5_0001, strb 0xF, PREADY=1 at first ACCESS cycle -> PSEL at N+1, PENABLE at N+2, PWDATA 0xA5A5_0001, PSTRB 0xF, ready pulse at N+3 with status 00, data 0.
- Read with 3 wait states, PRDATA 0xDEAD_BEEF -> PSTRB 0, PWDATA 0, ready at N+6, o_external_data 0xDEAD_BEEF, status 00.
- Read with PSLVERR=1 -> ready with status 10; ready high exactly 1 cycle.
- Two consecutive requests (valid drops 1 cycle after ready) -> two distinct APB transfers, no extra transfer started.
- Assert reset during ACCESS -> psel/penable 0 immediately, no ready; next request completes normally.
- With RGGEN_EXTERNAL_APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY held 0 -> after 4 ACCESS cycles psel drops, ready with status 10, data 0. PREADY=1 exactly at the 4th cycle -> status 00.
